// File: rtl/alu_pkg.sv
// alu_pkg: shared flag indices, flag vector type and condition-code encoding
//   FLAG_CF..FLAG_SF : bit positions inside every 5-bit flag vector
//   flags_t          : 5-bit flag vector, [0]CF [1]ZF [2]OF [3]PF [4]SF
//   cond_e           : 4-bit branch condition select
package alu_pkg;

    localparam int FLAG_CF = 0;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_PF = 3;
    localparam int FLAG_SF = 4;

    typedef logic [4:0] flags_t;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_CS = 4'd3,
        COND_CC = 4'd4,
        COND_MI = 4'd5,
        COND_PL = 4'd6,
        COND_VS = 4'd7,
        COND_VC = 4'd8,
        COND_PE = 4'd9,
        COND_PO = 4'd10,
        COND_A  = 4'd11,
        COND_BE = 4'd12,
        COND_GE = 4'd13,
        COND_LT = 4'd14,
        COND_LE = 4'd15
    } cond_e;

endpackage

// File: rtl/alu_flag_unit_cond_eval.sv
// cond_eval: combinational condition-code evaluation against a flag vector
//   flags_i : flag vector to test
//   cond_i  : condition select
//   cond_o  : 1 when the selected condition holds
module cond_eval
    import alu_pkg::*;
(
    input  flags_t flags_i,
    input  cond_e  cond_i,
    output logic   cond_o
);

    logic cf, zf, vf, pf, sf;

    assign cf = flags_i[FLAG_CF];
    assign zf = flags_i[FLAG_ZF];
    assign vf = flags_i[FLAG_OF];
    assign pf = flags_i[FLAG_PF];
    assign sf = flags_i[FLAG_SF];

    always_comb begin
        cond_o = 1'b1;
        case (cond_i)
            COND_AL: cond_o = 1'b1;
            COND_EQ: cond_o = zf;
            COND_NE: cond_o = ~zf;
            COND_CS: cond_o = cf;
            COND_CC: cond_o = ~cf;
            COND_MI: cond_o = sf;
            COND_PL: cond_o = ~sf;
            COND_VS: cond_o = vf;
            COND_VC: cond_o = ~vf;
            COND_PE: cond_o = pf;
            COND_PO: cond_o = ~pf;
            COND_A:  cond_o = ~cf & ~zf;
            COND_BE: cond_o = cf | zf;
            COND_GE: cond_o = ~(sf ^ vf);
            COND_LT: cond_o = sf ^ vf;
            COND_LE: cond_o = zf | (sf ^ vf);
            default: cond_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: architectural flag register with masked ALU capture, direct write, save/restore LIFO and condition evaluation
//   clk_i, rst_i        : clock, synchronous active-high reset
//   upd_i, mask_i       : capture ALU flags, per-flag enable
//   cf_i..sf_i          : flags from the active ALU block
//   wr_i, wr_data_i     : direct write of all flags
//   push_i, pop_i       : save / restore flags via the LIFO
//   cond_i, cond_o      : condition select and result on registered flags
//   flags_o             : registered flags
//   full_o, empty_o     : LIFO occupancy
//   err_o               : sticky LIFO misuse flag
module alu_flag_unit
    import alu_pkg::*;
#(
    parameter int STACK_DEPTH = 4
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       upd_i,
    input  logic [4:0] mask_i,
    input  logic       cf_i,
    input  logic       zf_i,
    input  logic       of_i,
    input  logic       pf_i,
    input  logic       sf_i,
    input  logic       wr_i,
    input  logic [4:0] wr_data_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [3:0] cond_i,
    output logic [4:0] flags_o,
    output logic       cond_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       err_o
);

    localparam int PW = $clog2(STACK_DEPTH + 1);
    // Array index width: just enough to address STACK_DEPTH entries.
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    flags_t        flags_q, flags_d, alu_flags, upd_flags;
    logic [PW-1:0] ptr_q, ptr_d, top_ptr;
    logic          err_q, err_d;
    logic          full, empty, do_push, do_pop, stack_err;
    flags_t        stack_q [STACK_DEPTH];

    assign alu_flags = {sf_i, pf_i, of_i, zf_i, cf_i};
    assign upd_flags = (mask_i & alu_flags) | (~mask_i & flags_q);
    assign top_ptr   = ptr_q - PW'(1);

    assign full  = (ptr_q == PW'(STACK_DEPTH));
    assign empty = (ptr_q == '0);

    // A simultaneous push and pop cancels both; either one alone is blocked at the boundary.
    assign do_push   = push_i & ~pop_i & ~full;
    assign do_pop    = pop_i & ~push_i & ~empty;
    assign stack_err = (push_i & pop_i) | (push_i & ~pop_i & full) | (pop_i & ~push_i & empty);

    always_comb begin
        flags_d = do_pop ? stack_q[top_ptr[IW-1:0]] : wr_i ? wr_data_i : upd_i ? upd_flags : flags_q;
        ptr_d   = do_push ? ptr_q + PW'(1) : do_pop ? top_ptr : ptr_q;
        err_d   = err_q | stack_err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; the push saves the pre-edge flags.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) stack_q[ptr_q[IW-1:0]] <= flags_q;
    end

    cond_eval u_cond_eval (
        .flags_i (flags_q),
        .cond_i  (cond_e'(cond_i)),
        .cond_o  (cond_o)
    );

    assign flags_o = flags_q;
    assign full_o  = full;
    assign empty_o = empty;
    assign err_o   = err_q;

endmodule
